// File: rtl/show_uart_tx.sv
// rtl/show_uart_tx.sv - UART 8N1 serialiser for debug trace frames
//
// Ports:
//   clk          system clock, all state updates on its rising edge
//   reset        asynchronous, active-low reset
//   tx_show      128-bit frame payload, byte k = tx_show[127-8k -: 8]
//   show_len     payload bytes to send (0..16, larger values clamp to 16)
//   frame_valid  one-cycle pulse offering a frame
//   frame_ready  high only while idle; frame accepted on valid & ready
//   busy         high from the cycle after acceptance to the end of the last stop bit
//   tx           registered UART line, idle high
//   drop_cnt     saturating count of frames offered while not ready
module show_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] tx_show,
  input  logic [4:0]   show_len,
  input  logic         frame_valid,
  output logic         frame_ready,
  output logic         busy,
  output logic         tx,
  output logic [7:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t         state_q, state_n;
  logic [15:0]    baud_q, baud_n;
  logic [2:0]     bit_q, bit_n;
  logic [3:0]     byte_q, byte_n;
  logic [4:0]     len_q, len_n;
  logic [127:0]   shbuf_q, shbuf_n;
  logic           tx_q, tx_n;
  logic           ready_q, busy_q;
  logic [7:0]     drop_q, drop_n;

  logic           baud_end;
  logic [4:0]     len_clamped;
  logic [7:0]     cur_byte;

  assign baud_end    = (baud_q == BAUD_LAST);
  assign len_clamped = (show_len > 5'd16) ? 5'd16 : show_len;

  // Next-state and datapath
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    len_n   = len_q;
    shbuf_n = shbuf_q;

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          shbuf_n = tx_show;
          len_n   = len_clamped;
          byte_n  = 4'd0;
          bit_n   = 3'd0;
          baud_n  = 16'd0;
          // A zero-length frame is consumed without leaving IDLE.
          if (len_clamped != 5'd0) begin
            state_n = START;
          end
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = 16'd0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = 16'd0;
          if (bit_q == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = 16'd0;
          if (({1'b0, byte_q} + 5'd1) < len_q) begin
            byte_n  = byte_q + 4'd1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_q + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Byte k of the latched buffer, MSB byte first.
  always_comb begin
    cur_byte = shbuf_n[127:120];
    for (int k = 0; k < 16; k++) begin
      if (byte_n == 4'(k)) begin
        cur_byte = shbuf_n[127-8*k -: 8];
      end
    end
  end

  // Line level is computed from the next state so tx is a plain flop.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_comb begin
    drop_n = drop_q;
    if (frame_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_n = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      len_q   <= 5'd0;
      shbuf_q <= 128'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      len_q   <= len_n;
      shbuf_q <= shbuf_n;
      tx_q    <= tx_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      drop_q  <= drop_n;
    end
  end

  assign tx          = tx_q;
  assign frame_ready = ready_q;
  assign busy        = busy_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_show_uart_tx.sv
// tb/tb_show_uart_tx.sv - directed self-checking bench for show_uart_tx
module tb_show_uart_tx;

  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] tx_show;
  logic [4:0]   show_len;
  logic         frame_valid;
  logic         frame_ready;
  logic         busy;
  logic         tx;
  logic [7:0]   drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int busy_acc    = 0;
  bit scramble    = 1'b0;

  show_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_show     (tx_show),
    .show_len    (show_len),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .tx          (tx),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_acc++;
    if (scramble) tx_show = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 1 (first start-bit cycle when length > 0).
  task automatic send(input logic [127:0] d, input logic [4:0] n);
    tx_show     = d;
    show_len    = n;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Entered in the first cycle of a start bit; samples each bit at its
  // second cycle and exits in the first cycle after the stop bit.
  // pulse 1: frame_valid during data bit 2; pulse 2: in the last stop cycle.
  task automatic expect_byte(input logic [7:0] b, input int pulse, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("%s bit%0d", tag, i), {31'b0, tx}, {31'b0, bits[i]});
      for (int j = 0; j < 3; j++) begin
        frame_valid = (pulse == 1 && i == 3 && j == 0) || (pulse == 2 && i == 9 && j == 2);
        tick();
      end
      frame_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!frame_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'b0, frame_ready}, 32'd1);
  endtask

  logic [127:0] seq16;
  logic [127:0] d12;

  initial begin
    seq16 = 128'h0102030405060708090A0B0C0D0E0F10;
    d12   = '0;
    for (int k = 0; k < 12; k++) d12[127-8*k -: 8] = 8'hA0 + 8'(k);

    // Reset state
    reset = 1'b0; tx_show = '0; show_len = '0; frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, frame_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Minimal frame A5
    busy_acc = 0;
    send({8'hA5, 120'h0}, 5'd1);
    expect_byte(8'hA5, 0, "a5");
    chk("a5_ready41", {31'b0, frame_ready}, 32'd1);
    chk("a5_busy41", {31'b0, busy}, 32'd0);
    chk("a5_busylen", busy_acc, 32'd40);

    // 16 bytes, MSB first, then same frame with clamped length 31
    busy_acc = 0;
    send(seq16, 5'd16);
    for (int k = 0; k < 16; k++) expect_byte(8'(k + 1), 0, $sformatf("l16 b%0d", k));
    chk("l16_busylen", busy_acc, 32'd640);
    busy_acc = 0;
    send(seq16, 5'd31);
    for (int k = 0; k < 16; k++) expect_byte(8'(k + 1), 0, $sformatf("l31 b%0d", k));
    chk("l31_busylen", busy_acc, 32'd640);

    // Length 0 then back-to-back frames
    send({128{1'b0}} | 128'hFFFF0000, 5'd0);
    chk("len0_ready", {31'b0, frame_ready}, 32'd1);
    chk("len0_busy", {31'b0, busy}, 32'd0);
    chk("len0_tx", {31'b0, tx}, 32'd1);
    repeat (5) tick();
    chk("len0_tx_later", {31'b0, tx}, 32'd1);
    chk("len0_busy_later", {31'b0, busy}, 32'd0);
    send({16'h1234, 112'h0}, 5'd2);
    expect_byte(8'h12, 0, "b2b0");
    expect_byte(8'h34, 0, "b2b1");
    chk("b2b_ready81", {31'b0, frame_ready}, 32'd1);
    chk("b2b_tx81", {31'b0, tx}, 32'd1);
    send({8'hC3, 120'h0}, 5'd1);
    chk("b2b_start82", {31'b0, tx}, 32'd0);
    expect_byte(8'hC3, 0, "b2b2");
    chk("b2b_drop", {24'b0, drop_cnt}, 32'd0);

    // Drops during a 12-byte frame, last one in the final stop cycle
    send(d12, 5'd12);
    for (int k = 0; k < 12; k++)
      expect_byte(8'hA0 + 8'(k), (k == 2 || k == 5) ? 1 : (k == 11 ? 2 : 0), $sformatf("drop b%0d", k));
    chk("drop_ready", {31'b0, frame_ready}, 32'd1);
    chk("drop_cnt3", {24'b0, drop_cnt}, 32'd3);
    tick();
    chk("drop_not_taken_tx", {31'b0, tx}, 32'd1);
    chk("drop_not_taken_busy", {31'b0, busy}, 32'd0);

    // Saturation
    send(seq16, 5'd16);
    repeat (300) begin
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      tick();
    end
    chk("drop_sat", {24'b0, drop_cnt}, 32'd255);
    wait_ready();
    chk("drop_sat_end", {24'b0, drop_cnt}, 32'd255);

    reset = 1'b0;
    tick();
    chk("rst2_drop", {24'b0, drop_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset during data bits of byte 1
    send({16'h5A96, 112'h0}, 5'd2);
    expect_byte(8'h5A, 0, "mid0");
    repeat (8) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, tx}, 32'd1);
    chk("mid_rst_ready", {31'b0, frame_ready}, 32'd1);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_idle_tx", {31'b0, tx}, 32'd1);
    send({8'h3C, 120'h0}, 5'd1);
    expect_byte(8'h3C, 0, "after_rst");

    // Input stability
    send({16'h55AA, 112'h0}, 5'd2);
    scramble = 1'b1;
    expect_byte(8'h55, 0, "stab0");
    expect_byte(8'hAA, 0, "stab1");
    scramble = 1'b0;
    chk("stab_ready", {31'b0, frame_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
